// File: rtl/crypto_round_ctrl.sv
// Multi-round byte cipher sequencer: key-XOR plus bit reversal, one round per cycle,
// with valid/ready handshakes on both the job input and the result output.
module crypto_round_ctrl #(
   parameter  int ROUNDS = 4,
   localparam int RW     = $clog2(ROUNDS+1)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   input  logic [7:0]    in_key,
   input  logic          in_decrypt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic          busy,
   output logic [RW-1:0] round_idx
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   typedef struct packed {
      logic       decrypt;
      logic [7:0] key;
   } job_t;

   localparam logic [RW-1:0] LAST = RW'(ROUNDS-1);

   state_t        state, state_nx;
   job_t          job_q;
   logic [7:0]    s_q;
   logic [RW-1:0] ridx_q;

   logic          last_round;
   logic [2:0]    rot;
   logic [15:0]   kk;
   logic [7:0]    k_r;
   logic [7:0]    round_out;

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // Decrypt counts down to 0, encrypt counts up to ROUNDS-1; both end on the round that hits the bound.
   assign last_round = job_q.decrypt ? (ridx_q == '0) : (ridx_q == LAST);
   assign rot        = 3'(ridx_q);
   assign kk         = {job_q.key, job_q.key} << rot;
   assign k_r        = kk[15:8];
   assign round_out  = job_q.decrypt ? (rev8(s_q) ^ k_r) : rev8(s_q ^ k_r);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)   state_nx = ROUND;
         ROUND:   if (last_round) state_nx = DONE;
         DONE:    if (out_ready)  state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      out_data  = (state == DONE) ? s_q : 8'h00;
      round_idx = ridx_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= 8'h00;
         job_q  <= '0;
         ridx_q <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               s_q           <= in_data;
               job_q.key     <= in_key;
               job_q.decrypt <= in_decrypt;
               ridx_q        <= in_decrypt ? LAST : '0;
            end
            ROUND: begin
               s_q <= round_out;
               // Encrypt may step to ROUNDS on its final round; that still fits in RW bits.
               if (!job_q.decrypt)    ridx_q <= ridx_q + RW'(1);
               else if (ridx_q != '0) ridx_q <= ridx_q - RW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crypto_round_ctrl.sv
// Bench for crypto_round_ctrl: table-driven vectors plus stall, abort and random
// encrypt/decrypt round-trip sequences, checked through an expected-result queue.
module tb_crypto_round_ctrl;

   localparam int ROUNDS = 4;
   localparam int RW     = $clog2(ROUNDS+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_decrypt;
   logic [7:0]    in_data, in_key;
   logic          out_valid, out_ready;
   logic [7:0]    out_data;
   logic          busy;
   logic [RW-1:0] round_idx;

   crypto_round_ctrl #(.ROUNDS(ROUNDS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_key(in_key), .in_decrypt(in_decrypt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .round_idx(round_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       dec;
      logic [7:0] key;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] sb_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   int         last_acc = -1;
   bit         spacing_on = 1'b0;
   bit         acc_now, ov_now;

   function automatic logic [7:0] m_rev(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = x[i];
      return r;
   endfunction

   function automatic logic [7:0] m_rotl(input logic [7:0] k, input int n);
      logic [7:0] r = k;
      repeat (n) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] m_enc(input logic [7:0] k, input logic [7:0] d);
      logic [7:0] s = d;
      for (int r = 0; r < ROUNDS; r++) s = m_rev(s ^ m_rotl(k, r % 8));
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sampled at the falling edge, i.e. the values the DUT sees at the next rising edge.
   task automatic observe();
      logic [7:0] e;
      acc_now = (in_valid === 1'b1) && (in_ready === 1'b1);
      ov_now  = (out_valid === 1'b1);
      if (acc_now) begin
         if (spacing_on && last_acc >= 0) chk("job_spacing", cyc - last_acc, ROUNDS + 2);
         last_acc = cyc;
      end
      if (ov_now && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got %0h expected no output (cycle %0d)", out_data, cyc);
         end else begin
            e = sb_q.pop_front();
            chk("out_data", out_data, e);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_acc();
      int n = 0;
      do begin tick(); n++; end while (!acc_now && n < 20);
      if (!acc_now) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
      end
   endtask

   // Latency counts cycles after the accept edge until the edge that sees out_valid high.
   task automatic run_job(input logic dec, input logic [7:0] key, input logic [7:0] data,
                          input logic [7:0] exp, input logic rdy);
      int n = 0;
      sb_q.push_back(exp);
      in_decrypt = dec; in_key = key; in_data = data;
      in_valid = 1'b1; out_ready = rdy;
      wait_acc();
      in_valid = 1'b0;
      do begin tick(); n++; end while (!ov_now && n < 50);
      chk("latency", n, ROUNDS + 1);
   endtask

   initial begin
      logic [7:0] k, d, c;
      vecs[0] = '{1'b0, 8'h01, 8'h00, 8'h55};
      vecs[1] = '{1'b1, 8'h01, 8'h55, 8'h00};
      vecs[2] = '{1'b0, 8'h00, 8'hA5, 8'hA5};
      vecs[3] = '{1'b1, 8'h00, 8'hA5, 8'hA5};
      vecs[4] = '{1'b0, 8'hFF, 8'hFF, 8'hFF};
      vecs[5] = '{1'b1, 8'hFF, 8'h00, 8'h00};

      rst = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; in_data = 8'h00; in_key = 8'h00; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_round_idx", round_idx, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++)
         run_job(vecs[i].dec, vecs[i].key, vecs[i].data, vecs[i].exp, 1'b1);
      chk("table_drained", sb_q.size(), 0);

      // Output stall with an ignored input pulse in the middle.
      run_job(1'b0, 8'h01, 8'h00, 8'h55, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin in_valid = 1'b1; in_data = 8'hFF; in_key = 8'h33; end
         if (i == 4) in_valid = 1'b0;
         tick();
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, 8'h55);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      chk("post_hs_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
      for (int i = 0; i < ROUNDS + 3; i++) begin
         tick();
         chk("ignored_pulse_no_job", busy, 0);
      end

      // Reset during round 2 discards the job.
      in_decrypt = 1'b0; in_key = 8'h3C; in_data = 8'h5A; in_valid = 1'b1;
      wait_acc();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid_round_idx", round_idx, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_data", out_data, 8'h00);
      chk("abort_busy", busy, 0);
      chk("abort_round_idx", round_idx, 0);
      for (int i = 0; i < ROUNDS + 4; i++) begin
         tick();
         chk("abort_no_output", out_valid, 0);
      end

      // Random round trips, back to back with in_valid held high.
      spacing_on = 1'b1; last_acc = -1; out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         k = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         c = m_enc(k, d);
         sb_q.push_back(c);
         in_decrypt = 1'b0; in_key = k; in_data = d;
         wait_acc();
         sb_q.push_back(d);
         in_decrypt = 1'b1; in_key = k; in_data = c;
         wait_acc();
      end
      in_valid = 1'b0;
      for (int n = 0; n < 50 && sb_q.size() != 0; n++) tick();
      chk("random_drained", sb_q.size(), 0);
      spacing_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
